// File: rtl/jtag_dtm.sv
// RISC-V debug transport module: IEEE 1149.1 TAP with IDCODE/DTMCS/DMI/BYPASS
// registers and a valid/ready DMI request/response port, all on jtag_TCK.
module jtag_dtm #(
   parameter int                 DMI_ADDR_BITS = 6,
   parameter int                 DMI_DATA_BITS = 32,
   parameter int                 IR_BITS       = 5,
   parameter logic [31:0]        IDCODE_VALUE  = 32'h1E200A6F,
   parameter int                 IDLE_CYCLES   = 5,
   parameter logic [IR_BITS-1:0] IR_IDCODE     = 'h01,
   parameter logic [IR_BITS-1:0] IR_DTMCS      = 'h10,
   parameter logic [IR_BITS-1:0] IR_DMI        = 'h11
) (
   input  logic                                   jtag_TCK,
   input  logic                                   rst_n,
   input  logic                                   jtag_TMS,
   input  logic                                   jtag_TDI,
   output logic                                   jtag_TDO,
   output logic                                   dmi_req_valid_o,
   input  logic                                   dmi_req_ready_i,
   output logic [DMI_ADDR_BITS+DMI_DATA_BITS+1:0] dmi_req_o,
   input  logic                                   dmi_resp_valid_i,
   output logic                                   dmi_resp_ready_o,
   input  logic [DMI_DATA_BITS+1:0]               dmi_resp_i,
   output logic                                   dmi_hardreset_o
);

   localparam int A   = DMI_ADDR_BITS;
   localparam int D   = DMI_DATA_BITS;
   localparam int SRW = A + D + 2;
   localparam logic [2:0] IDLE3 = 3'(IDLE_CYCLES);
   localparam logic [5:0] ABITS = 6'(DMI_ADDR_BITS);

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
   } tap_t;

   typedef enum logic [1:0] {DMI_IDLE, DMI_REQ, DMI_RSP} dmi_t;

   tap_t tap, tap_nxt;
   dmi_t dmi, dmi_nxt;

   logic [IR_BITS-1:0] ir;
   logic [SRW-1:0]     sr, sr_shift, dr_cap;
   logic [A-1:0]       last_addr;
   logic [D-1:0]       last_data;
   logic [1:0]         last_op, sticky, cap_op;
   logic               sel_idcode, sel_dtmcs, sel_dmi;
   logic               issue, hard, resp_take;

   assign sel_idcode = (ir == IR_IDCODE);
   assign sel_dtmcs  = (ir == IR_DTMCS);
   assign sel_dmi    = (ir == IR_DMI);

   assign issue = (tap == UPD_DR) && sel_dmi && (dmi == DMI_IDLE) && (sticky == 2'd0) &&
                  ((sr[1:0] == 2'd1) || (sr[1:0] == 2'd2));
   assign hard      = (tap == UPD_DR) && sel_dtmcs && sr[17];
   assign resp_take = (dmi == DMI_RSP) && dmi_resp_valid_i && !hard;

   assign dmi_req_valid_o  = (dmi == DMI_REQ);
   assign dmi_resp_ready_o = (dmi == DMI_RSP);

   always_comb begin
      tap_nxt = tap;
      case (tap)
         TLR:    tap_nxt = jtag_TMS ? TLR    : RTI;
         RTI:    tap_nxt = jtag_TMS ? SEL_DR : RTI;
         SEL_DR: tap_nxt = jtag_TMS ? SEL_IR : CAP_DR;
         CAP_DR: tap_nxt = jtag_TMS ? EX1_DR : SH_DR;
         SH_DR:  tap_nxt = jtag_TMS ? EX1_DR : SH_DR;
         EX1_DR: tap_nxt = jtag_TMS ? UPD_DR : PA_DR;
         PA_DR:  tap_nxt = jtag_TMS ? EX2_DR : PA_DR;
         EX2_DR: tap_nxt = jtag_TMS ? UPD_DR : SH_DR;
         UPD_DR: tap_nxt = jtag_TMS ? SEL_DR : RTI;
         SEL_IR: tap_nxt = jtag_TMS ? TLR    : CAP_IR;
         CAP_IR: tap_nxt = jtag_TMS ? EX1_IR : SH_IR;
         SH_IR:  tap_nxt = jtag_TMS ? EX1_IR : SH_IR;
         EX1_IR: tap_nxt = jtag_TMS ? UPD_IR : PA_IR;
         PA_IR:  tap_nxt = jtag_TMS ? EX2_IR : PA_IR;
         EX2_IR: tap_nxt = jtag_TMS ? UPD_IR : SH_IR;
         UPD_IR: tap_nxt = jtag_TMS ? SEL_DR : RTI;
      endcase
   end

   // A hardreset in the same cycle as ready/resp-valid discards the transaction.
   always_comb begin
      dmi_nxt = dmi;
      case (dmi)
         DMI_IDLE: if (issue)            dmi_nxt = DMI_REQ;
         DMI_REQ:  if (dmi_req_ready_i)  dmi_nxt = DMI_RSP;
         DMI_RSP:  if (dmi_resp_valid_i) dmi_nxt = DMI_IDLE;
         default:                        dmi_nxt = DMI_IDLE;
      endcase
      if (hard) dmi_nxt = DMI_IDLE;
   end

   always_ff @(posedge jtag_TCK) begin
      if (!rst_n) begin
         tap <= TLR;
         dmi <= DMI_IDLE;
      end else begin
         tap <= tap_nxt;
         dmi <= dmi_nxt;
      end
   end

   always_comb begin
      cap_op = (dmi != DMI_IDLE) ? 2'd3 : ((sticky != 2'd0) ? sticky : last_op);
      dr_cap = '0;
      if (sel_dmi)
         dr_cap = {last_addr, last_data, cap_op};
      else if (sel_dtmcs)
         dr_cap[31:0] = {14'b0, 2'b0, 1'b0, IDLE3, sticky, ABITS, 4'h1};
      else if (sel_idcode)
         dr_cap[31:0] = IDCODE_VALUE;
   end

   // TDI enters at the top of the currently active register length.
   always_comb begin
      sr_shift = sr >> 1;
      if (tap == SH_IR)
         sr_shift[IR_BITS-1] = jtag_TDI;
      else if (sel_dmi)
         sr_shift[SRW-1] = jtag_TDI;
      else if (sel_idcode || sel_dtmcs)
         sr_shift[31] = jtag_TDI;
      else
         sr_shift[0] = jtag_TDI;
   end

   always_ff @(posedge jtag_TCK) begin
      if (!rst_n) begin
         sr              <= '0;
         dmi_req_o       <= '0;
         last_addr       <= '0;
         last_data       <= '0;
         last_op         <= '0;
         sticky          <= '0;
         dmi_hardreset_o <= 1'b0;
      end else begin
         dmi_hardreset_o <= hard;
         case (tap)
            CAP_IR:       sr <= SRW'(1);
            CAP_DR:       sr <= dr_cap;
            SH_IR, SH_DR: sr <= sr_shift;
            default:      ;
         endcase
         if (issue) begin
            dmi_req_o <= sr;
            last_addr <= sr[SRW-1 -: A];
         end
         if (resp_take) begin
            last_data <= dmi_resp_i[D+1:2];
            last_op   <= dmi_resp_i[1:0];
         end
         // Later assignments take priority: busy over failed, clear over all.
         if (resp_take && (dmi_resp_i[1:0] == 2'd2) && (sticky == 2'd0))
            sticky <= 2'd2;
         if ((tap == CAP_DR) && sel_dmi && (dmi != DMI_IDLE))
            sticky <= 2'd3;
         if ((tap == UPD_DR) && sel_dtmcs && (sr[16] || sr[17]))
            sticky <= 2'd0;
      end
   end

   always_ff @(negedge jtag_TCK) begin
      jtag_TDO <= ((tap == SH_IR) || (tap == SH_DR)) ? sr[0] : 1'b0;
      if (tap == TLR)
         ir <= IR_IDCODE;
      else if (tap == UPD_IR)
         ir <= sr[IR_BITS-1:0];
   end

endmodule

// File: tb/tb_jtag_dtm.sv
// Scoreboard bench for jtag_dtm: scan captures and DMI requests are queued as
// expected values when issued and checked by independent monitors.
module tb_jtag_dtm;
   localparam int A = 6;
   localparam int D = 32;
   localparam int W = A + D + 2;

   logic         tck = 1'b0, rst_n = 1'b0, tms = 1'b1, tdi = 1'b0;
   logic         tdo, req_valid, req_ready = 1'b0, resp_valid = 1'b0, resp_ready, hr;
   logic [W-1:0] req;
   logic [D+1:0] resp = '0;

   always #5 tck = ~tck;

   jtag_dtm dut (
      .jtag_TCK(tck), .rst_n(rst_n), .jtag_TMS(tms), .jtag_TDI(tdi), .jtag_TDO(tdo),
      .dmi_req_valid_o(req_valid), .dmi_req_ready_i(req_ready), .dmi_req_o(req),
      .dmi_resp_valid_i(resp_valid), .dmi_resp_ready_o(resp_ready), .dmi_resp_i(resp),
      .dmi_hardreset_o(hr)
   );

   int checks = 0, failures = 0, hr_cnt = 0;

   typedef struct {
      string        nm;
      logic [W-1:0] val;
      int           w;
   } scan_t;

   scan_t        scan_q[$];
   logic [W-1:0] req_q[$];
   logic [W-1:0] scan_word;
   event         scan_ev;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [W-1:0] dmi(input logic [5:0] a, input logic [31:0] d,
                                        input logic [1:0] op);
      return {a, d, op};
   endfunction

   task automatic push_scan(input string nm, input logic [W-1:0] val, input int w);
      scan_t e;
      e.nm = nm; e.val = val; e.w = w;
      scan_q.push_back(e);
   endtask

   task automatic tick(input logic m, input logic d, output logic o);
      @(negedge tck);
      tms = m;
      tdi = d;
      #1 o = tdo;
   endtask

   task automatic idle(input int n);
      logic o;
      repeat (n) tick(1'b0, 1'b0, o);
   endtask

   task automatic shift_ir(input logic [4:0] code);
      logic o;
      logic [W-1:0] cap;
      push_scan("capture_ir", W'(1), 5);
      tick(1, 0, o); tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
      cap = '0;
      for (int i = 0; i < 5; i++) begin
         tick(i == 4, code[i], o);
         cap[i] = o;
      end
      tick(1, 0, o); tick(0, 0, o);
      scan_word = cap;
      ->scan_ev;
   endtask

   task automatic shift_dr(input string nm, input int w, input logic [W-1:0] din,
                           input logic [W-1:0] exp);
      logic o;
      logic [W-1:0] cap;
      push_scan(nm, exp, w);
      tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
      cap = '0;
      for (int i = 0; i < w; i++) begin
         tick(i == w - 1, din[i], o);
         cap[i] = o;
      end
      tick(1, 0, o); tick(0, 0, o);
      scan_word = cap;
      ->scan_ev;
   endtask

   task automatic handshake();
      @(negedge tck);
      req_ready = 1'b1;
      @(negedge tck);
      req_ready = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] op);
      @(negedge tck);
      resp_valid = 1'b1;
      resp = {d, op};
      @(negedge tck);
      resp_valid = 1'b0;
      resp = '0;
   endtask

   // Scan monitor: each completed scan is compared against the oldest expectation.
   always @(scan_ev) begin
      scan_t e;
      logic [W-1:0] m;
      if (scan_q.size() == 0) chk("scan_unexpected", 1, 0);
      else begin
         e = scan_q.pop_front();
         m = (e.w >= W) ? '1 : ((W'(1) << e.w) - W'(1));
         chk(e.nm, 64'(scan_word & m), 64'(e.val & m));
      end
   end

   // Request monitor: a new request must match the queue head and stay stable.
   logic         prev_v = 1'b0, prev_hr = 1'b0;
   logic [W-1:0] prev_r = '0;
   always begin
      @(negedge tck);
      #2;
      if (req_valid && !prev_v) begin
         if (req_q.size() == 0) chk("req_unexpected", 1, 0);
         else chk("req_issue", 64'(req), 64'(req_q.pop_front()));
      end else if (req_valid && prev_v && (req !== prev_r))
         chk("req_stable", 64'(req), 64'(prev_r));
      if (hr && prev_hr) chk("hardreset_width", 2, 1);
      if (hr && !prev_hr) hr_cnt++;
      prev_v  = req_valid;
      prev_r  = req;
      prev_hr = hr;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic o;
      repeat (2) @(negedge tck);
      #1;
      chk("rst_req_valid", req_valid, 0);
      chk("rst_resp_ready", resp_ready, 0);
      chk("rst_hardreset", hr, 0);
      chk("rst_tdo", tdo, 0);
      chk("rst_req", 64'(req), 0);
      rst_n = 1'b1;
      tick(0, 0, o);

      shift_dr("idcode", 32, '0, W'(32'h1E200A6F));
      shift_ir(5'h1F);
      shift_dr("bypass", 8, W'(8'hB5), W'(8'h6A));
      shift_ir(5'h10);
      shift_dr("dtmcs", 32, '0, W'(32'h00005061));

      // Write held for three cycles without ready, then acknowledged.
      shift_ir(5'h11);
      req_q.push_back(dmi(6'h10, 32'h1, 2'd2));
      shift_dr("dmi_cap_reset", W, dmi(6'h10, 32'h1, 2'd2), '0);
      repeat (3) begin
         @(negedge tck);
         #1;
         chk("req_hold_valid", req_valid, 1);
         chk("req_hold_data", 64'(req), 64'(dmi(6'h10, 32'h1, 2'd2)));
      end
      handshake();
      #1 chk("rsp_ready_after_accept", resp_ready, 1);
      respond(32'h12345678, 2'd0);
      shift_dr("dmi_cap_ok", W, dmi(6'h3F, 32'h0, 2'd0), dmi(6'h10, 32'h12345678, 2'd0));

      // Busy: capture while awaiting the response.
      req_q.push_back(dmi(6'h05, 32'h0, 2'd1));
      shift_dr("dmi_nop_keeps_addr", W, dmi(6'h05, 32'h0, 2'd1), dmi(6'h10, 32'h12345678, 2'd0));
      handshake();
      shift_dr("dmi_cap_busy", W, dmi(6'h07, 32'h0, 2'd1), dmi(6'h05, 32'h12345678, 2'd3));
      idle(3);
      #1;
      chk("busy_no_req", req_valid, 0);
      chk("busy_still_rsp", resp_ready, 1);
      respond(32'hAAAA5555, 2'd0);
      shift_ir(5'h10);
      shift_dr("dtmcs_busy", 32, '0, W'(32'h00005C61));
      shift_ir(5'h11);
      shift_dr("dmi_sticky_busy", W, dmi(6'h07, 32'h0, 2'd1), dmi(6'h05, 32'hAAAA5555, 2'd3));
      idle(3);
      #1 chk("sticky_no_req", req_valid, 0);
      shift_ir(5'h10);
      shift_dr("dtmcs_dmireset", 32, W'(32'h00010000), W'(32'h00005C61));
      shift_ir(5'h11);
      req_q.push_back(dmi(6'h09, 32'h0, 2'd1));
      shift_dr("dmi_after_clear", W, dmi(6'h09, 32'h0, 2'd1), dmi(6'h05, 32'hAAAA5555, 2'd0));
      handshake();
      respond(32'hDEAD0001, 2'd2);

      // Failed op blocks further requests until dmireset.
      shift_dr("dmi_failed", W, dmi(6'h0A, 32'h55, 2'd2), dmi(6'h09, 32'hDEAD0001, 2'd2));
      idle(3);
      #1 chk("failed_no_req", req_valid, 0);
      shift_ir(5'h10);
      shift_dr("dtmcs_failed", 32, W'(32'h00010000), W'(32'h00005861));
      shift_ir(5'h11);
      req_q.push_back(dmi(6'h0A, 32'h55, 2'd2));
      shift_dr("dmi_last_op_failed", W, dmi(6'h0A, 32'h55, 2'd2), dmi(6'h09, 32'hDEAD0001, 2'd2));
      @(negedge tck);
      #1 chk("req_before_abort", req_valid, 1);

      // Hardreset abort while the request is still pending.
      shift_ir(5'h10);
      shift_dr("dtmcs_hardreset", 32, W'(32'h00020000), W'(32'h00005061));
      @(negedge tck);
      #1;
      chk("abort_valid_low", req_valid, 0);
      chk("abort_pulse", hr, 1);
      resp_valid = 1'b1;
      resp = {32'h00000BAD, 2'd0};
      chk("abort_resp_ready", resp_ready, 0);
      @(negedge tck);
      #1;
      chk("abort_pulse_end", hr, 0);
      chk("abort_resp_ready_late", resp_ready, 0);
      resp_valid = 1'b0;
      chk("hardreset_pulses", hr_cnt, 1);
      shift_ir(5'h11);
      shift_dr("dmi_after_abort", W, '0, dmi(6'h0A, 32'hDEAD0001, 2'd2));

      // Five TMS=1 clocks return to Test-Logic-Reset and reselect IDCODE.
      repeat (5) tick(1, 0, o);
      tick(0, 0, o);
      shift_dr("idcode_after_tlr", 32, '0, W'(32'h1E200A6F));

      idle(2);
      chk("scan_queue_drained", scan_q.size(), 0);
      chk("req_queue_drained", req_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/jtag_dtm.md
# jtag_dtm

Parametrised RISC-V JTAG Debug Transport Module (debug spec 0.13 DTM) on the `jtag_TCK` domain. It provides:
- a full TAP state machine;
- configurable IR/IDCODE/DMI widths;
- sticky DMI error/busy reporting;
- `dmireset`/`dmihardreset` support;
- a valid/ready DMI request and response port toward the clock-domain-crossing handshake stage that feeds the Debug Module.

It supersedes the fixed-width, busy-only DTM by adding failed-op reporting, true 1-bit BYPASS, NOP filtering and transaction abort.

## Interface
Parameters:
- `DMI_ADDR_BITS`, 6: DMI address width; reported in `dtmcs.abits`.
- `DMI_DATA_BITS`, 32: DMI data width.
- `IR_BITS`, 5: instruction register width (≥5).
- `IDCODE_VALUE`, 32'h1E200A6F: IDCODE register content (bit 0 must be 1).
- `IDLE_CYCLES`, 5: value reported in `dtmcs.idle` (3 bits).
- `IR_IDCODE`, 'h01: IR code selecting IDCODE.
- `IR_DTMCS`, 'h10: IR code selecting DTMCS.
- `IR_DMI`, 'h11: IR code selecting DMI.

Ports (let A = `DMI_ADDR_BITS`, D = `DMI_DATA_BITS`):
- `jtag_TCK` in 1: single clock. Rising edge drives all state; falling edge drives only `jtag_TDO` and the IR update.
- `rst_n` in 1: reset, synchronous, active-low.
- `jtag_TMS` in 1: TAP mode select.
- `jtag_TDI` in 1: serial data in.
- `jtag_TDO` out 1: serial data out.
- `dmi_req_valid_o` out 1: DMI request valid.
- `dmi_req_ready_i` in 1: DM accepts the request.
- `dmi_req_o` out A+D+2: {addr, data, op}; op 1 = read, 2 = write.
- `dmi_resp_valid_i` in 1: DM response valid.
- `dmi_resp_ready_o` out 1: DTM accepts the response.
- `dmi_resp_i` in D+2: {data, op}; op 0 = ok, 2 = failed.
- `dmi_hardreset_o` out 1: one-cycle pulse on `dmihardreset`.

## Operation
- **TAP:** the standard 16-state IEEE 1149.1 FSM, with transitions on rising `jtag_TCK` from `jtag_TMS`. Five TMS=1 clocks from any state reach Test-Logic-Reset.
- **Shift register:** width A+D+2, shifted LSB first, TDI entering at the MSB of the active length.
  - Active length is `IR_BITS` for IR, 1 for BYPASS, 32 for IDCODE/DTMCS, A+D+2 for DMI.
- **Capture-IR:** loads ...01.
- **IR update:** on the falling edge in Update-IR, IR takes the shifted value. In Test-Logic-Reset, IR = `IR_IDCODE`. Any unrecognised IR code acts as BYPASS.
- **Capture-DR per IR:**
  - BYPASS: 0.
  - IDCODE: `IDCODE_VALUE`.
  - DTMCS: {14'b0, 2'b0, 1'b0, `IDLE_CYCLES`[2:0], dmistat, A[5:0], 4'h1}.
  - DMI: {last addr, last resp data, op}.
- **DMI capture op:**
  - If the DMI FSM ≠ IDLE, sticky is set to 3 and op = 3.
  - Otherwise op = sticky if sticky ≠ 0, else the last response op.
- **Sticky / dmistat:** 2-bit `sticky` ∈ {0, 2, 3}; dmistat = sticky.
  - A response with op = 2 sets sticky = 2 only when sticky = 0.
  - A busy condition (3) overrides 0 or 2.
- **Update-DR, IR = DMI:** issues a request only when all of the following hold:
  - FSM = IDLE;
  - sticky = 0;
  - shifted op ∈ {1, 2}.
  
  When issued, `dmi_req_o` latches the shifted value and the FSM moves to REQ. Op 0 and op 3 are ignored. The last addr is updated only when a request issues.
- **Update-DR, IR = DTMCS:**
  - bit 16 (`dmireset`) clears sticky.
  - bit 17 (`dmihardreset`) clears sticky, forces the FSM to IDLE, deasserts `dmi_req_valid_o`, and pulses `dmi_hardreset_o`.
- **DMI FSM:**
  - IDLE → REQ on issue.
  - REQ → RSP on `dmi_req_valid_o` & `dmi_req_ready_i`.
  - RSP → IDLE on `dmi_resp_valid_i`, which stores resp data and op.
  - `dmi_req_valid_o` = (state == REQ).
  - `dmi_resp_ready_o` = (state == RSP).
  - Responses arriving outside RSP are dropped.
- **Reset** (`rst_n` low at a rising edge):
  - TAP → Test-Logic-Reset; FSM → IDLE; sticky = 0.
  - Last addr/data/op = 0; `dmi_req_o` = 0.
  - `dmi_req_valid_o`, `dmi_resp_ready_o`, `dmi_hardreset_o` = 0.
  - `jtag_TDO` = 0 at the next falling edge; IR = `IR_IDCODE` at the next falling edge.

## Timing
- `jtag_TDO` is updated on the falling edge: shift_reg[0] in Shift-IR/Shift-DR, else 0.
- **Request latency:** at the rising edge that leaves Update-DR, state = REQ, so `dmi_req_valid_o` is high in the following cycle. It holds high, with stable `dmi_req_o`, until ready is sampled.
- **Response:** stored at the accepting rising edge. Data becomes visible at the next Capture-DR.
- **Simultaneous events:**
  - Capture-DR on the same edge as an accepted response: uses the pre-edge FSM state (busy), so sticky = 3.
  - `dmihardreset` on the same edge as ready or resp valid: hardreset wins and the transaction is discarded.
  - Response op 2 while sticky = 3: sticky stays 3.
- **Reset mid-transaction:** outputs clear at that edge. No response is awaited afterward.

## Test plan
- **IDCODE after reset:** `rst_n` low 2 cycles, then TMS 0 to Run-Test/Idle, then shift 32 DR bits → TDO stream equals 32'h1E200A6F, LSB first.
- **DTMCS read:** IR = 'h10, shift 32 bits → 32'h00005061 (idle 5, abits 6, version 1, dmistat 0).
- **DMI write:** IR = 'h11, shift {addr 6'h10, data 32'h1, op 2}, then Update-DR.
  - Required: `dmi_req_valid_o` high next cycle with `dmi_req_o` = {6'h10, 32'h1, 2'd2}, held for 3 cycles while ready = 0.
  - After ready: response {32'h0, op 0} → next capture returns op 0.
- **Busy path:** capture DMI while the FSM is in RSP → op 3 and dmistat 3.
  - A following Update-DR op 1 issues no request.
  - Writing DTMCS bit 16 clears sticky → the next read issues.
- **Failed op:** response op 2 → capture returns op 2 and dmistat 2. Requests are blocked until `dmireset`.
- **Hardreset abort:** while in REQ, write DTMCS bit 17 → `dmi_req_valid_o` low next cycle, a 1-cycle `dmi_hardreset_o` pulse, FSM IDLE, and a late `dmi_resp_valid_i` is ignored (`dmi_resp_ready_o` = 0).
